mem_stage_ctrl: RTL and testbench

Consumer of the EX/MEM pipeline register outputs; implements the MEM stage of the 5-stage pipeline. Resolves jump/beq/bne and issues PC redirect plus flush. Drives a variable-latency data memory over a req/ack handshake and stalls the pipeline until the access completes. Holds the MEM/WB register, presenting registered write-back values to the WB stage.

---
 rtl/mem_stage_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: branch resolution, req/ack data-memory sequencing with stall, MEM/WB register.
// Optional build macro MEM_TIMEOUT_EN aborts an access that waits TIMEOUT_CYCLES in ACCESS without mem_ack.
module mem_stage_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Jump,
    input  logic              Branch,
    input  logic              Bne,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              zero,
    input  logic [31:0]       ALUresult,
    input  logic [31:0]       regData2,
    input  logic [4:0]        WriteReg,
    input  logic [31:0]       target,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              PCSrc,
    output logic [31:0]       pc_target,
    output logic              flush,
    output logic              wb_RegWrite,
    output logic              wb_MemtoReg,
    output logic [31:0]       wb_readData,
    output logic [31:0]       wb_ALUresult,
    output logic [4:0]        wb_WriteReg,
    output logic              mem_err
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t state, next_state;

    logic mem_op;
    logic misaligned;
    logic access;
    logic timeout;
    logic retire_bubble;
    logic load_done;

    assign mem_op     = MemRead | MemWrite;
    assign misaligned = mem_op & (ALUresult[1:0] != 2'b00);
    assign access     = mem_op & ~misaligned;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] timeout_cnt;

    // Counter sits at zero while IDLE, so it is zero on the first ACCESS cycle.
    assign timeout = (state == ACCESS) && (timeout_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
        end else if (state == IDLE) begin
            timeout_cnt <= '0;
        end else if (!timeout) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // An aborted access drops mem_req so EX/MEM can advance past the failed instruction.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                mem_req = access;
                if (access && !mem_ack) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (timeout) begin
                    next_state = IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        next_state = IDLE;
                    end
                end
            end
        endcase
        if (!rst_n) begin
            mem_req = 1'b0;
        end
    end

    assign stall     = mem_req & ~mem_ack;
    assign mem_we    = MemWrite;
    assign mem_addr  = ALUresult[ADDR_W-1:0];
    assign mem_wdata = regData2;

    assign PCSrc     = Jump | (Branch & zero) | (Bne & ~zero);
    assign pc_target = target;
    assign flush     = PCSrc;

    assign retire_bubble = misaligned | timeout;
    assign load_done     = mem_req & mem_ack & MemRead;

    // A stalled cycle inserts a bubble but keeps the previous data fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_RegWrite  <= 1'b0;
            wb_MemtoReg  <= 1'b0;
            wb_readData  <= '0;
            wb_ALUresult <= '0;
            wb_WriteReg  <= '0;
        end else if (stall) begin
            wb_RegWrite <= 1'b0;
            wb_MemtoReg <= 1'b0;
        end else begin
            wb_RegWrite  <= RegWrite & ~retire_bubble;
            wb_MemtoReg  <= MemtoReg & ~retire_bubble;
            wb_ALUresult <= ALUresult;
            wb_WriteReg  <= WriteReg;
            if (load_done) begin
                wb_readData <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else if (misaligned || timeout) begin
            mem_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl; expectations are hand-computed per vector.
// Covers the MEM_TIMEOUT_EN behaviour when that macro is defined, indefinite waiting otherwise.
module tb_mem_stage_ctrl;

    // Control vector bit order: {Jump, Branch, Bne, MemRead, MemWrite, MemtoReg, RegWrite, zero}
    localparam logic [7:0] C_NOP = 8'b0000_0000;
    localparam logic [7:0] C_LW  = 8'b0001_0110;
    localparam logic [7:0] C_SW  = 8'b0000_1000;
    localparam logic [7:0] C_ALU = 8'b0000_0010;

    logic        clk;
    logic        rst_n;
    logic        Jump, Branch, Bne, MemRead, MemWrite, MemtoReg, RegWrite, zero;
    logic [31:0] ALUresult, regData2, target, mem_rdata;
    logic [4:0]  WriteReg;
    logic        mem_ack;
    logic        mem_req, mem_we, stall, PCSrc, flush;
    logic [31:0] mem_addr, mem_wdata, pc_target;
    logic        wb_RegWrite, wb_MemtoReg, mem_err;
    logic [31:0] wb_readData, wb_ALUresult;
    logic [4:0]  wb_WriteReg;

    int checkCount = 0;
    int passCount  = 0;
    int stallCycles;
    int reqCycles;

    mem_stage_ctrl #(
        .ADDR_W        (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Jump        (Jump),
        .Branch      (Branch),
        .Bne         (Bne),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .zero        (zero),
        .ALUresult   (ALUresult),
        .regData2    (regData2),
        .WriteReg    (WriteReg),
        .target      (target),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall       (stall),
        .PCSrc       (PCSrc),
        .pc_target   (pc_target),
        .flush       (flush),
        .wb_RegWrite (wb_RegWrite),
        .wb_MemtoReg (wb_MemtoReg),
        .wb_readData (wb_readData),
        .wb_ALUresult(wb_ALUresult),
        .wb_WriteReg (wb_WriteReg),
        .mem_err     (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives one EX/MEM vector plus memory response, then lets combinational outputs settle.
    task automatic applyStimulus(input logic [7:0] ctrl, input logic [31:0] alu, input logic [31:0] rd2,
                                 input logic [4:0] wr, input logic [31:0] tgt,
                                 input logic ack, input logic [31:0] rdata);
        {Jump, Branch, Bne, MemRead, MemWrite, MemtoReg, RegWrite, zero} = ctrl;
        ALUresult = alu;
        regData2  = rd2;
        WriteReg  = wr;
        target    = tgt;
        mem_ack   = ack;
        mem_rdata = rdata;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  brCtrl [5];
        logic        brExp  [5];
        logic [31:0] brTgt  [5];

        rst_n = 1'b0;
        applyStimulus(C_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        checkOutput("reset mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("reset stall", {31'b0, stall}, 32'd0);
        checkOutput("reset wb_RegWrite", {31'b0, wb_RegWrite}, 32'd0);
        checkOutput("reset wb_readData", wb_readData, 32'd0);
        checkOutput("reset mem_err", {31'b0, mem_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait load
        @(negedge clk);
        applyStimulus(C_LW, 32'h10, 32'h0, 5'd8, 32'h0, 1'b1, 32'hDEADBEEF);
        checkOutput("lw0 mem_req", {31'b0, mem_req}, 32'd1);
        checkOutput("lw0 stall", {31'b0, stall}, 32'd0);
        checkOutput("lw0 mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("lw0 mem_addr", mem_addr, 32'h10);
        @(negedge clk);
        checkOutput("lw0 wb_readData", wb_readData, 32'hDEADBEEF);
        checkOutput("lw0 wb_WriteReg", {27'b0, wb_WriteReg}, 32'd8);
        checkOutput("lw0 wb_RegWrite", {31'b0, wb_RegWrite}, 32'd1);
        checkOutput("lw0 wb_MemtoReg", {31'b0, wb_MemtoReg}, 32'd1);

        // ALU op with no memory access
        applyStimulus(C_ALU, 32'h55, 32'h0, 5'd3, 32'h0, 1'b0, 32'h0);
        checkOutput("alu mem_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        checkOutput("alu wb_ALUresult", wb_ALUresult, 32'h55);
        checkOutput("alu wb_RegWrite", {31'b0, wb_RegWrite}, 32'd1);
        checkOutput("alu wb_MemtoReg", {31'b0, wb_MemtoReg}, 32'd0);

        // Store acknowledged in its fourth cycle
        applyStimulus(C_SW, 32'h20, 32'h1234, 5'd0, 32'h0, 1'b0, 32'h0);
        stallCycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (stall) stallCycles++;
            checkOutput("sw mem_we", {31'b0, mem_we}, 32'd1);
            checkOutput("sw mem_wdata", mem_wdata, 32'h1234);
            @(negedge clk);
            checkOutput("sw bubble wb_RegWrite", {31'b0, wb_RegWrite}, 32'd0);
            checkOutput("sw bubble wb_ALUresult held", wb_ALUresult, 32'h55);
        end
        mem_ack = 1'b1;
        #1;
        if (stall) stallCycles++;
        checkOutput("sw stall cycles", stallCycles, 32'd3);
        checkOutput("sw ack mem_req", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        checkOutput("sw wb_ALUresult", wb_ALUresult, 32'h20);
        checkOutput("sw wb_RegWrite", {31'b0, wb_RegWrite}, 32'd0);
        checkOutput("sw wb_readData held", wb_readData, 32'hDEADBEEF);

        // Ack without request is ignored; also confirms the FSM returned to IDLE
        applyStimulus(C_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h99999999);
        checkOutput("stray ack mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("stray ack stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        checkOutput("stray ack wb_readData", wb_readData, 32'hDEADBEEF);

        // Load with one wait cycle
        applyStimulus(C_LW, 32'h44, 32'h0, 5'd5, 32'h0, 1'b0, 32'h11111111);
        checkOutput("lw1 stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        checkOutput("lw1 ack stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        checkOutput("lw1 wb_readData", wb_readData, 32'hCAFEF00D);
        checkOutput("lw1 wb_WriteReg", {27'b0, wb_WriteReg}, 32'd5);
        checkOutput("lw1 wb_RegWrite", {31'b0, wb_RegWrite}, 32'd1);

        // Branch resolution table
        brCtrl[0] = 8'b0010_0000; brExp[0] = 1'b1; brTgt[0] = 32'h40;
        brCtrl[1] = 8'b0010_0001; brExp[1] = 1'b0; brTgt[1] = 32'h80;
        brCtrl[2] = 8'b0100_0001; brExp[2] = 1'b1; brTgt[2] = 32'h100;
        brCtrl[3] = 8'b0100_0000; brExp[3] = 1'b0; brTgt[3] = 32'h104;
        brCtrl[4] = 8'b1000_0000; brExp[4] = 1'b1; brTgt[4] = 32'h200;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(brCtrl[i], 32'h0, 32'h0, 5'd0, brTgt[i], 1'b0, 32'h0);
            checkOutput($sformatf("br%0d PCSrc", i), {31'b0, PCSrc}, {31'b0, brExp[i]});
            checkOutput($sformatf("br%0d flush", i), {31'b0, flush}, {31'b0, brExp[i]});
            checkOutput($sformatf("br%0d pc_target", i), pc_target, brTgt[i]);
            checkOutput($sformatf("br%0d mem_req", i), {31'b0, mem_req}, 32'd0);
            @(negedge clk);
        end

        // Misaligned load
        applyStimulus(C_LW, 32'h13, 32'h0, 5'd9, 32'h0, 1'b0, 32'h0);
        checkOutput("misal mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("misal stall", {31'b0, stall}, 32'd0);
        checkOutput("misal mem_err before edge", {31'b0, mem_err}, 32'd0);
        @(negedge clk);
        checkOutput("misal mem_err", {31'b0, mem_err}, 32'd1);
        checkOutput("misal wb_RegWrite", {31'b0, wb_RegWrite}, 32'd0);
        applyStimulus(C_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("misal mem_err sticky", {31'b0, mem_err}, 32'd1);

        // Reset in the middle of an access
        applyStimulus(C_LW, 32'h8, 32'h0, 5'd7, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("rst mid mem_req before", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst mid mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst mid stall", {31'b0, stall}, 32'd0);
        checkOutput("rst mid wb_ALUresult", wb_ALUresult, 32'd0);
        checkOutput("rst mid wb_readData", wb_readData, 32'd0);
        checkOutput("rst mid wb_WriteReg", {27'b0, wb_WriteReg}, 32'd0);
        checkOutput("rst mid mem_err", {31'b0, mem_err}, 32'd0);
        applyStimulus(C_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst release idle mem_req", {31'b0, mem_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Load that never gets acknowledged is aborted after 4 ACCESS cycles
        applyStimulus(C_LW, 32'h30, 32'h0, 5'd4, 32'h0, 1'b0, 32'h0);
        reqCycles = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req) reqCycles++;
            @(negedge clk);
            #1;
        end
        checkOutput("tmo req cycles", reqCycles, 32'd5);
        checkOutput("tmo mem_req dropped", {31'b0, mem_req}, 32'd0);
        checkOutput("tmo stall dropped", {31'b0, stall}, 32'd0);
        @(negedge clk);
        checkOutput("tmo mem_err", {31'b0, mem_err}, 32'd1);
        checkOutput("tmo wb_RegWrite", {31'b0, wb_RegWrite}, 32'd0);
        applyStimulus(C_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
`else
        // Without the timeout the access waits as long as it takes
        applyStimulus(C_LW, 32'h30, 32'h0, 5'd4, 32'h0, 1'b0, 32'h0);
        stallCycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (stall) stallCycles++;
        end
        checkOutput("long wait stall cycles", stallCycles, 32'd10);
        checkOutput("long wait mem_err", {31'b0, mem_err}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        #1;
        checkOutput("long wait ack stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        checkOutput("long wait wb_readData", wb_readData, 32'h0BADF00D);
        checkOutput("long wait wb_RegWrite", {31'b0, wb_RegWrite}, 32'd1);
        applyStimulus(C_NOP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
